// File: rtl/round_referee.sv
`default_nettype none
// ============================================================================
//  Module      : round_referee
//  Description : Tug-of-war round referee. Watches the two edge lights and
//                the players' press pulses, declares round winners, keeps
//                per-player scores, holds the winner indication for
//                HOLD_CYCLES cycles, then pulses roundReset into the light
//                chain. Freezes once a player reaches MAX_SCORE.
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous active-high clear
//                leftEdgeOn   - lightOn of the leftmost edge light
//                rightEdgeOn  - lightOn of the rightmost edge light
//                pressL/R     - one-cycle press pulses (debounced, edged)
//                roundReset   - one-cycle pulse restarting the light chain
//                winL/winR    - round or match winner indication
//                scoreL/R     - per-player scores
//                matchOver    - match ended; frozen until reset
//  Revision    : 1.0 - initial release
// ============================================================================
module round_referee #(
    parameter int SCORE_W     = 3,
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               leftEdgeOn,
    input  logic               rightEdgeOn,
    input  logic               pressL,
    input  logic               pressR,
    output logic               roundReset,
    output logic               winL,
    output logic               winR,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic               matchOver
);

    // Hold counter only needs to reach HOLD_CYCLES-1; keep at least one bit.
    localparam int                 c_CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] c_MAX       = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        S_PLAY       = 2'd0,
        S_HOLD       = 2'd1,
        S_ROUND_RST  = 2'd2,
        S_MATCH_OVER = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_hold_cnt;
    logic                 r_round_reset;
    logic                 r_win_l;
    logic                 r_win_r;
    logic [SCORE_W-1:0]   r_score_l;
    logic [SCORE_W-1:0]   r_score_r;
    logic                 r_match_over;

    logic                 w_lw;
    logic                 w_rw;
    logic [SCORE_W-1:0]   w_score_l_inc;
    logic [SCORE_W-1:0]   w_score_r_inc;

    // A player wins by pressing while their own edge light is lit.
    assign w_lw          = leftEdgeOn  & pressL;
    assign w_rw          = rightEdgeOn & pressR;
    // Scores never exceed MAX_SCORE, so the increment cannot wrap.
    assign w_score_l_inc = r_score_l + SCORE_W'(1);
    assign w_score_r_inc = r_score_r + SCORE_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_PLAY;
            r_hold_cnt    <= '0;
            r_round_reset <= 1'b0;
            r_win_l       <= 1'b0;
            r_win_r       <= 1'b0;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_match_over  <= 1'b0;
        end else begin
            // roundReset is a single-cycle pulse; only the HOLD exit raises it.
            r_round_reset <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    // Simultaneous wins are a tie: nothing changes.
                    if (w_lw && !w_rw) begin
                        r_score_l  <= w_score_l_inc;
                        r_win_l    <= 1'b1;
                        r_hold_cnt <= c_HOLD_LOAD;
                        if (w_score_l_inc == c_MAX) begin
                            r_state      <= S_MATCH_OVER;
                            r_match_over <= 1'b1;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else if (w_rw && !w_lw) begin
                        r_score_r  <= w_score_r_inc;
                        r_win_r    <= 1'b1;
                        r_hold_cnt <= c_HOLD_LOAD;
                        if (w_score_r_inc == c_MAX) begin
                            r_state      <= S_MATCH_OVER;
                            r_match_over <= 1'b1;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state       <= S_ROUND_RST;
                        r_round_reset <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - c_CNT_W'(1);
                    end
                end
                S_ROUND_RST: begin
                    r_win_l <= 1'b0;
                    r_win_r <= 1'b0;
                    r_state <= S_PLAY;
                end
                S_MATCH_OVER: begin
                    // Frozen until reset; flags and scores hold their values.
                    r_state <= S_MATCH_OVER;
                end
            endcase
        end
    end

    assign roundReset = r_round_reset;
    assign winL       = r_win_l;
    assign winR       = r_win_r;
    assign scoreL     = r_score_l;
    assign scoreR     = r_score_r;
    assign matchOver  = r_match_over;

endmodule
`default_nettype wire

// File: doc/round_referee.md
# round_referee

Game referee for the tug-of-war playfield. Watches the two edge lights (the `lightOn` outputs of the leftmost and rightmost edge-light cells) together with the players' press pulses, and declares a round winner when a player pushes the lit edge off the board. It keeps per-player scores and holds the winner indication for a programmable time. It then pulses a round reset back into the light chain and freezes the game once a player reaches the match score.

## Interface
Parameters:
- `SCORE_W`, 3, width of each score counter
- `MAX_SCORE`, 7, score that ends the match; must satisfy 1 ≤ MAX_SCORE ≤ 2^SCORE_W−1
- `HOLD_CYCLES`, 4, cycles the winner is displayed before the round reset; must be ≥ 1

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-high; clears everything
- `leftEdgeOn`  in  1  `lightOn` of the leftmost edge light
- `rightEdgeOn`  in  1  `lightOn` of the rightmost edge light
- `pressL`  in  1  one-cycle press pulse from the left player; already debounced and edge-detected
- `pressR`  in  1  one-cycle press pulse from the right player; already debounced and edge-detected
- `roundReset`  out  1  one-cycle pulse that resets the light chain for a new round
- `winL`  out  1  left player won the current round or the match
- `winR`  out  1  right player won the current round or the match
- `scoreL`  out  SCORE_W  left player's score
- `scoreR`  out  SCORE_W  right player's score
- `matchOver`  out  1  the match has ended; the block is frozen until `reset`

All outputs are registered.

## Operation
- States: PLAY, HOLD, ROUND_RST, MATCH_OVER.
- Round-win conditions, evaluated only in PLAY:
  - lw = `leftEdgeOn` & `pressL`
  - rw = `rightEdgeOn` & `pressR`
- PLAY transitions:
  - lw & ~rw: left wins the round.
    - `scoreL` increments.
    - `winL` is set.
    - The hold counter loads HOLD_CYCLES−1.
    - Go to HOLD, or to MATCH_OVER if the new `scoreL` equals MAX_SCORE.
  - rw & ~lw: mirror of the left case for the right player.
  - lw & rw (both edges lit and both players press in the same cycle): treated as a tie.
    - No score change.
    - Stay in PLAY.
  - Neither condition: stay in PLAY.
- HOLD:
  - `winL`/`winR` stay steady.
  - All inputs are ignored.
  - The counter decrements each cycle.
  - When the counter is 0, go to ROUND_RST.
- ROUND_RST:
  - `roundReset` = 1 for exactly this one cycle.
  - `winL` and `winR` clear when leaving the state.
  - Next state is PLAY.
- MATCH_OVER:
  - The winning flag stays at 1.
  - The scores stay frozen.
  - `matchOver` = 1.
  - `roundReset` stays 0.
  - All inputs are ignored.
  - The state is left only by `reset`.
- Score arithmetic:
  - Unsigned, SCORE_W bits.
  - A score can never exceed MAX_SCORE, so no wrap is possible.
- At most one of `winL` and `winR` is high at any time.

## Timing
- Reset values: state PLAY, and every output is 0, including `roundReset`, `winL`, `winR`, `scoreL`, `scoreR` and `matchOver`.
- `reset` has priority over every other input in every state. Asserting it during HOLD, ROUND_RST or MATCH_OVER returns the block to PLAY with all outputs 0 on the next edge, and no `roundReset` pulse is produced.
- Win latency:
  - The win condition is sampled at edge N.
  - After edge N, the score and win flag show their new values.
  - `roundReset` is high during the cycle after edge N+HOLD_CYCLES.
  - Leaving ROUND_RST, `winL` and `winR` clear and PLAY resumes.
  - A new win can be sampled at edge N+HOLD_CYCLES+2 at the earliest.
- Presses arriving during HOLD or ROUND_RST are dropped, not queued.
- Edge-light inputs are used as they arrive, with no synchronizer, because they come from the same clock domain.

## Test plan
Bench parameters: HOLD_CYCLES=4, MAX_SCORE=3, SCORE_W=3.

1. Reset, then hold all inputs at 0 for 5 cycles -> all outputs stay 0; state PLAY.
2. `leftEdgeOn`=1 with a `pressL` pulse at edge N -> after N, `scoreL`=1 and `winL`=1; `roundReset`=1 during the cycle after edge N+4 only; `winL`=0 after N+5.
3. `leftEdgeOn`=1 and `rightEdgeOn`=1 with `pressL` and `pressR` in the same cycle -> no score change, no win flag, no `roundReset`.
4. Right win, then keep `pressR`=1 with `rightEdgeOn`=1 throughout HOLD -> `scoreR`=1, not higher; presses are ignored until PLAY resumes.
5. Three left wins -> `scoreL`=3, `matchOver`=1 and `winL`=1 stay set indefinitely; no `roundReset` after the third win; further presses have no effect.
6. Assert `reset` in the second HOLD cycle -> after the next edge all outputs are 0; no `roundReset` pulse is produced; a fresh win scores 1.
